alu_core: RTL and testbench

- Registered N-bit MIPS-style integer ALU, selected by a 6-bit funct-style opcode.
- Combinationally computes one of eight operations on two operands.
- Registers the result on the rising clock edge.
- Sits in the execute stage; operands and opcode are driven by upstream switch/register logic, and the result drives display or writeback.

---
 rtl/alu_core.sv | 60 ++++++
 tb/tb_alu_core.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// Registered N-bit MIPS-style integer ALU: eight funct-coded operations on two
// operands, result captured on the rising clock edge with one cycle of latency.
module alu_core #(
  parameter int N    = 8,
  parameter int N_op = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    date_a,
  input  logic [N-1:0]    date_b,
  input  logic [N_op-1:0] op,
  output logic [N-1:0]    result
);

  localparam logic [N_op-1:0] OP_ADD = N_op'(6'b100000);
  localparam logic [N_op-1:0] OP_SUB = N_op'(6'b100010);
  localparam logic [N_op-1:0] OP_AND = N_op'(6'b100100);
  localparam logic [N_op-1:0] OP_OR  = N_op'(6'b100101);
  localparam logic [N_op-1:0] OP_XOR = N_op'(6'b100110);
  localparam logic [N_op-1:0] OP_NOR = N_op'(6'b100111);
  localparam logic [N_op-1:0] OP_SRL = N_op'(6'b000010);
  localparam logic [N_op-1:0] OP_SRA = N_op'(6'b000011);

  logic [N-1:0]        result_d;
  logic [N-1:0]        result_q;
  logic signed [N-1:0] sra_val;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    result_d = '0;
    // NOTE: the arithmetic shift lives in its own signed variable; inside a mixed
    // unsigned expression the operand would be coerced unsigned and zero-fill instead.
    sra_val  = $signed(date_a) >>> date_b;

    unique case (op)
      OP_ADD:  result_d = date_a + date_b;
      OP_SUB:  result_d = date_a - date_b;
      OP_AND:  result_d = date_a & date_b;
      OP_OR:   result_d = date_a | date_b;
      OP_XOR:  result_d = date_a ^ date_b;
      OP_NOR:  result_d = ~(date_a | date_b);
      // Shift amounts at or beyond N saturate: zeros for SRL, sign fill for SRA.
      OP_SRL:  result_d = date_a >> date_b;
      OP_SRA:  result_d = $unsigned(sra_val);
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (reset) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed boundary steps followed by random
// traffic compared against an integer-arithmetic reference model.
module tb_alu_core;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] date_a;
  logic [7:0] date_b;
  logic [5:0] op;
  logic [7:0] result;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_core #(.N(8), .N_op(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .date_a (date_a),
    .date_b (date_b),
    .op     (op),
    .result (result)
  );

  always #5 clk = ~clk;

  // Reference computed from the arithmetic definitions, using plain integers.
  function automatic logic [7:0] ref_alu(input logic [5:0] o, input int a, input int b);
    int r;
    int sa;
    int d;
    r = 0;
    case (o)
      OP_ADD: r = (a + b) % 256;
      OP_SUB: r = (a - b + 256) % 256;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOR: r = 255 - (a | b);
      OP_SRL: r = (b >= 8) ? 0 : a / (1 << b);
      OP_SRA: begin
        sa = (a >= 128) ? a - 256 : a;
        if (b >= 8) begin
          r = (sa < 0) ? -1 : 0;
        end else begin
          d = 1 << b;
          r = (sa >= 0) ? sa / d : -((-sa + d - 1) / d);
        end
      end
      default: r = 0;
    endcase
    r = r & 255;
    return r[7:0];
  endfunction

  task automatic check(input string tag, input logic [7:0] expected);
    n_cmp++;
    assert (result === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, result, expected);
    end
  endtask

  // Drive inputs, take one clock edge, then sample 1 time unit after it.
  task automatic step(input logic rst, input logic [5:0] o, input logic [7:0] a,
                      input logic [7:0] b, input string tag, input logic [7:0] expected);
    reset  = rst;
    op     = o;
    date_a = a;
    date_b = b;
    @(posedge clk);
    #1;
    check(tag, expected);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] ops [8];
    logic [5:0] o;
    logic [7:0] a;
    logic [7:0] b;
    logic       r;
    int         sel;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRL, OP_SRA};

    #2;
    step(1'b1, OP_ADD, 8'h37, 8'h42, "reset_c1", 8'h00);
    step(1'b1, OP_OR,  8'hFF, 8'hFF, "reset_c2", 8'h00);

    step(1'b0, OP_ADD, 8'h01, 8'h01, "add_01_01", 8'h02);
    step(1'b0, OP_SUB, 8'h01, 8'h01, "sub_01_01", 8'h00);
    step(1'b0, OP_AND, 8'h01, 8'h01, "and_01_01", 8'h01);
    step(1'b0, OP_OR,  8'h01, 8'h01, "or_01_01",  8'h01);
    step(1'b0, OP_XOR, 8'h01, 8'h01, "xor_01_01", 8'h00);
    step(1'b0, OP_NOR, 8'h01, 8'h01, "nor_01_01", 8'hFE);

    // Between edges the output must not follow the inputs.
    op = OP_ADD; date_a = 8'h10; date_b = 8'h20;
    #3;
    check("hold_between_edges", 8'hFE);

    step(1'b0, OP_SRL, 8'hFF, 8'h01, "srl_ff_1", 8'h7F);
    step(1'b0, OP_SRA, 8'hFF, 8'h01, "sra_ff_1", 8'hFF);
    step(1'b0, OP_SRL, 8'h80, 8'h03, "srl_80_3", 8'h10);
    step(1'b0, OP_SRA, 8'h80, 8'h03, "sra_80_3", 8'hF0);

    step(1'b0, OP_ADD, 8'hFF, 8'h01, "add_wrap", 8'h00);
    step(1'b0, OP_SUB, 8'h00, 8'h01, "sub_wrap", 8'hFF);
    step(1'b0, OP_SRL, 8'hFF, 8'h08, "srl_b8",   8'h00);
    step(1'b0, OP_SRA, 8'h80, 8'hFF, "sra_bff",  8'hFF);
    step(1'b0, OP_SRA, 8'h7F, 8'h09, "sra_pos_b9", 8'h00);
    step(1'b0, OP_SRL, 8'hC3, 8'h00, "srl_b0",   8'hC3);
    step(1'b0, OP_SRA, 8'hC3, 8'h00, "sra_b0",   8'hC3);
    step(1'b0, OP_SRA, 8'hC3, 8'h07, "sra_b7",   8'hFF);
    step(1'b0, OP_SRL, 8'hC3, 8'h10, "srl_b16",  8'h00);

    step(1'b0, 6'b111111, 8'h5A, 8'hA5, "undef_3f", 8'h00);
    step(1'b0, OP_XOR,    8'h5A, 8'hA5, "xor_5a_a5", 8'hFF);
    step(1'b0, 6'b000000, 8'h5A, 8'hA5, "undef_00", 8'h00);

    step(1'b0, OP_OR,  8'h0F, 8'hF0, "pre_reset",   8'hFF);
    step(1'b1, OP_ADD, 8'h01, 8'h01, "reset_wins",  8'h00);
    step(1'b0, OP_ADD, 8'h01, 8'h01, "after_reset", 8'h02);

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      o   = (sel > 7) ? 6'($urandom_range(0, 63)) : ops[sel];
      a   = 8'($urandom_range(0, 255));
      b   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom_range(0, 255));
      r   = ($urandom_range(0, 19) == 0);
      step(r, o, a, b, "random", r ? 8'h00 : ref_alu(o, int'(a), int'(b)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
